// File: rtl/code_lock_param_if.sv
// Keypad-side and bolt-side signals of the code lock, grouped for port connection.
// The keypad scanner/bench drives through master; the lock core attaches as slave.
interface code_lock_param_if #(
    parameter int MAX_FAILS = 3
) ();
    localparam int FW = $clog2(MAX_FAILS + 1);

    logic [3:0]    key;
    logic          pressed;
    logic          enter;
    logic          set_code;
    logic          unlocked;
    logic          lockout;
    logic [FW-1:0] fail_count;
    logic          code_set;

    modport master (
        output key, pressed, enter, set_code,
        input  unlocked, lockout, fail_count, code_set
    );

    modport slave (
        input  key, pressed, enter, set_code,
        output unlocked, lockout, fail_count, code_set
    );
endinterface

// File: rtl/code_lock_param.sv
// Parametrised keypad code lock: digit capture, code compare, unlock timer, owner code change.
// Define CODE_LOCK_LOCKOUT_EN to add the failed-attempt LOCKOUT state and its timer.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_LOCKED   | door bolted, collecting digits, enter submits the entry
// S_UNLOCKED | door released while the timer runs; owner may store a code
// S_LOCKOUT  | keypad ignored until the lockout timer expires
module code_lock_param #(
    parameter int                  DIGITS         = 4,
    parameter int                  UNLOCK_CYCLES  = 9,
    parameter int                  MAX_FAILS      = 3,
    parameter int                  LOCKOUT_CYCLES = 64,
    parameter logic [DIGITS*4-1:0] RESET_CODE     = 16'h1234
) (
    input logic              clk,
    input logic              rst_n,
    code_lock_param_if.slave bus
);
    localparam int BW   = DIGITS * 4;
    localparam int CW   = $clog2(DIGITS + 1);
    localparam int FW   = $clog2(MAX_FAILS + 1);
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);
    localparam logic [FW-1:0] FAIL_ONE = FW'(1);
    localparam logic [TW-1:0] T_UNLOCK = TW'(UNLOCK_CYCLES);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
`ifdef CODE_LOCK_LOCKOUT_EN
    localparam logic [TW-1:0] T_LOCKOUT = TW'(LOCKOUT_CYCLES);
`endif

    typedef enum logic [1:0] {
        S_LOCKED   = 2'd0,
        S_UNLOCKED = 2'd1,
        S_LOCKOUT  = 2'd2
    } state_t;

    state_t        r_state;
    logic [BW-1:0] r_code;
    logic [BW-1:0] r_buf;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_timer;
    logic [FW-1:0] r_fail;
    logic          r_unlocked;
    logic          r_code_set;

    state_t        w_state_nxt;
    logic [BW-1:0] w_code_nxt;
    logic [BW-1:0] w_buf_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic [FW-1:0] w_fail_nxt;
    logic          w_code_set_nxt;
    logic          w_digit;
    logic          w_match;
    logic [BW-1:0] w_buf_shift;
    logic [CW-1:0] w_cnt_inc;
    logic [FW-1:0] w_fail_inc;

    // enter and set_code both swallow a digit presented in the same cycle
    assign w_digit     = bus.pressed && (bus.key < 4'd10) && !bus.enter && !bus.set_code;
    assign w_match     = (r_cnt == CNT_FULL) && (r_buf == r_code);
    assign w_buf_shift = (r_buf << 4) | BW'(bus.key);
    assign w_cnt_inc   = (r_cnt == CNT_FULL) ? r_cnt : (r_cnt + CNT_ONE);
    assign w_fail_inc  = r_fail + FAIL_ONE;

    always_comb begin
        w_state_nxt    = r_state;
        w_code_nxt     = r_code;
        w_buf_nxt      = r_buf;
        w_cnt_nxt      = r_cnt;
        w_timer_nxt    = r_timer;
        w_fail_nxt     = r_fail;
        w_code_set_nxt = 1'b0;

        case (r_state)
            S_LOCKED: begin
                if (bus.enter) begin
                    w_buf_nxt = '0;
                    w_cnt_nxt = '0;
                    if (w_match) begin
                        w_state_nxt = S_UNLOCKED;
                        w_timer_nxt = T_UNLOCK;
                        w_fail_nxt  = '0;
                    end else begin
`ifdef CODE_LOCK_LOCKOUT_EN
                        w_fail_nxt = w_fail_inc;
                        if (w_fail_inc == FAIL_MAX) begin
                            w_state_nxt = S_LOCKOUT;
                            w_timer_nxt = T_LOCKOUT;
                        end
`else
                        if (r_fail != FAIL_MAX) begin
                            w_fail_nxt = w_fail_inc;
                        end
`endif
                    end
                end else if (w_digit) begin
                    w_buf_nxt = w_buf_shift;
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            S_UNLOCKED: begin
                w_timer_nxt = r_timer - T_ONE;
                if (r_timer <= T_ONE) begin
                    w_state_nxt = S_LOCKED;
                    w_timer_nxt = '0;
                end
                if (bus.enter) begin
                    w_state_nxt = S_LOCKED;
                    w_timer_nxt = '0;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (bus.set_code) begin
                    // a partial entry leaves both the code and the entry untouched
                    if (r_cnt == CNT_FULL) begin
                        w_code_nxt     = r_buf;
                        w_code_set_nxt = 1'b1;
                        w_buf_nxt      = '0;
                        w_cnt_nxt      = '0;
                    end
                end else if (w_digit) begin
                    w_buf_nxt = w_buf_shift;
                    w_cnt_nxt = w_cnt_inc;
                end
            end

`ifdef CODE_LOCK_LOCKOUT_EN
            S_LOCKOUT: begin
                w_timer_nxt = r_timer - T_ONE;
                if (r_timer <= T_ONE) begin
                    w_state_nxt = S_LOCKED;
                    w_timer_nxt = '0;
                    w_fail_nxt  = '0;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
`endif

            default: begin
                w_state_nxt = S_LOCKED;
                w_timer_nxt = '0;
                w_buf_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_LOCKED;
            r_code     <= RESET_CODE;
            r_buf      <= '0;
            r_cnt      <= '0;
            r_timer    <= '0;
            r_fail     <= '0;
            r_unlocked <= 1'b0;
            r_code_set <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_code     <= w_code_nxt;
            r_buf      <= w_buf_nxt;
            r_cnt      <= w_cnt_nxt;
            r_timer    <= w_timer_nxt;
            r_fail     <= w_fail_nxt;
            r_unlocked <= (w_state_nxt == S_UNLOCKED);
            r_code_set <= w_code_set_nxt;
        end
    end

`ifdef CODE_LOCK_LOCKOUT_EN
    logic r_lockout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lockout <= 1'b0;
        end else begin
            r_lockout <= (w_state_nxt == S_LOCKOUT);
        end
    end

    assign bus.lockout = r_lockout;
`else
    assign bus.lockout = 1'b0;
`endif

    assign bus.unlocked   = r_unlocked;
    assign bus.fail_count = r_fail;
    assign bus.code_set   = r_code_set;
endmodule
